// File: rtl/cnt_v1.sv
// ---------------------------------------------------------------------------
// cnt_v1 : 12-LED pattern sequencer for the board LED bank.
//
// A prescaler produces one step tick every DIV clocks while the sequencer is
// running. On each tick the FSM moves the single lit LED left (RUN_L) or
// right (RUN_R), or toggles the whole bank (FLASH). The sequence then
// returns to RUN_L and repeats.
//
// Ports
//   clk    in   1   system clock, all logic on the rising edge
//   rst_n  in   1   synchronous reset, ACTIVE-HIGH despite the name
//   en     in   1   run enable; 0 forces IDLE on the next edge
//   led    out 12   registered LED drive, 1 = lit
//   s_cur  out  2   registered current state (IDLE=0 RUN_L=1 RUN_R=2 FLASH=3)
// ---------------------------------------------------------------------------
module cnt_v1 #(
  parameter int DIV         = 4,  // clocks per step tick, >= 2
  parameter int FLASH_TICKS = 4   // ticks spent in FLASH, >= 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic [11:0] led,
  output logic [1:0]  s_cur
);

  localparam int DIV_W = $clog2(DIV);
  // A single flash tick would give a zero-width counter, so keep one bit minimum.
  localparam int FLASH_W = (FLASH_TICKS > 1) ? $clog2(FLASH_TICKS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
  localparam logic [FLASH_W-1:0] FLASH_LAST = FLASH_W'(FLASH_TICKS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN_L = 2'd1,
    RUN_R = 2'd2,
    FLASH = 2'd3
  } state_t;

  state_t               state_r;
  state_t               state_nxt_s;
  logic [11:0]          led_r;
  logic [11:0]          led_nxt_s;
  logic [DIV_W-1:0]     div_cnt_r;
  logic [DIV_W-1:0]     div_cnt_nxt_s;
  logic [FLASH_W-1:0]   flash_cnt_r;
  logic [FLASH_W-1:0]   flash_cnt_nxt_s;
  logic                 tick_s;

  // Step tick: last prescaler count while running.
  always_comb begin
    tick_s = (state_r != IDLE) && en && (div_cnt_r == DIV_LAST);
  end

  // Next-state, next-LED and counter logic.
  always_comb begin
    state_nxt_s     = state_r;
    led_nxt_s       = led_r;
    div_cnt_nxt_s   = div_cnt_r;
    flash_cnt_nxt_s = flash_cnt_r;

    if (!en) begin
      state_nxt_s     = IDLE;
      led_nxt_s       = 12'h000;
      div_cnt_nxt_s   = {DIV_W{1'b0}};
      flash_cnt_nxt_s = {FLASH_W{1'b0}};
    end else begin
      // Prescaler runs in every non-IDLE state; explicit wrap supports any DIV.
      if (state_r == IDLE) begin
        div_cnt_nxt_s = {DIV_W{1'b0}};
      end else if (tick_s) begin
        div_cnt_nxt_s = {DIV_W{1'b0}};
      end else begin
        div_cnt_nxt_s = div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
      end

      case (state_r)
        IDLE: begin
          state_nxt_s     = RUN_L;
          led_nxt_s       = 12'h001;
          flash_cnt_nxt_s = {FLASH_W{1'b0}};
        end
        RUN_L: begin
          if (!tick_s) begin
            led_nxt_s = led_r;
          end else if (led_r == 12'h800) begin
            // Leftmost reached: turn around, skipping a repeat of bit 11.
            state_nxt_s = RUN_R;
            led_nxt_s   = 12'h400;
          end else begin
            led_nxt_s = {led_r[10:0], 1'b0};
          end
        end
        RUN_R: begin
          if (!tick_s) begin
            led_nxt_s = led_r;
          end else if (led_r == 12'h001) begin
            state_nxt_s     = FLASH;
            led_nxt_s       = 12'hFFF;
            flash_cnt_nxt_s = {FLASH_W{1'b0}};
          end else begin
            led_nxt_s = {1'b0, led_r[11:1]};
          end
        end
        FLASH: begin
          if (!tick_s) begin
            led_nxt_s = led_r;
          end else if (flash_cnt_r == FLASH_LAST) begin
            state_nxt_s     = RUN_L;
            led_nxt_s       = 12'h001;
            flash_cnt_nxt_s = {FLASH_W{1'b0}};
          end else begin
            led_nxt_s       = ~led_r;
            flash_cnt_nxt_s = flash_cnt_r + {{(FLASH_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          state_nxt_s     = IDLE;
          led_nxt_s       = 12'h000;
          div_cnt_nxt_s   = {DIV_W{1'b0}};
          flash_cnt_nxt_s = {FLASH_W{1'b0}};
        end
      endcase
    end
  end

  // State and datapath registers; rst_n is an active-high synchronous reset.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_r     <= IDLE;
      led_r       <= 12'h000;
      div_cnt_r   <= {DIV_W{1'b0}};
      flash_cnt_r <= {FLASH_W{1'b0}};
    end else begin
      state_r     <= state_nxt_s;
      led_r       <= led_nxt_s;
      div_cnt_r   <= div_cnt_nxt_s;
      flash_cnt_r <= flash_cnt_nxt_s;
    end
  end

  assign led   = led_r;
  assign s_cur = state_r;

endmodule

// File: tb/tb_cnt_v1.sv
module tb_cnt_v1;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [11:0] led;
  logic [1:0]  s_cur;

  int checks = 0;
  int errors = 0;

  cnt_v1 #(.DIV(4), .FLASH_TICKS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .led   (led),
    .s_cur (s_cur)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] exp_led, input logic [1:0] exp_st);
    checks++;
    assert (led === exp_led) else begin
      errors++;
      $error("FAIL %s led: observed %h expected %h", tag, led, exp_led);
    end
    checks++;
    assert (s_cur === exp_st) else begin
      errors++;
      $error("FAIL %s s_cur: observed %0d expected %0d", tag, s_cur, exp_st);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    en    = 1'b1;

    // Reset held with en=1: stays IDLE, dark.
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk("reset", 12'h000, 2'd0);
    end

    // Start: release reset, edge k.
    rst_n = 1'b0;
    step(1);  chk("start_k",    12'h001, 2'd1);
    step(3);  chk("hold_k3",    12'h001, 2'd1);
    step(1);  chk("shift_k4",   12'h002, 2'd1);
    step(4);  chk("shift_k8",   12'h004, 2'd1);
    step(36); chk("left_k44",   12'h800, 2'd1);
    step(3);  chk("hold_k47",   12'h800, 2'd1);
    step(1);  chk("turn_k48",   12'h400, 2'd2);
    step(4);  chk("right_k52",  12'h200, 2'd2);
    step(36); chk("right_k88",  12'h001, 2'd2);
    step(4);  chk("flash_k92",  12'hFFF, 2'd3);
    step(4);  chk("flash_k96",  12'h000, 2'd3);
    step(4);  chk("flash_k100", 12'hFFF, 2'd3);
    step(4);  chk("flash_k104", 12'h000, 2'd3);
    step(4);  chk("wrap_k108",  12'h001, 2'd1);

    // Second pass into RUN_R, then drop enable mid-shift.
    step(48); chk("turn2_k156", 12'h400, 2'd2);
    step(6);  chk("mid_r_k162", 12'h200, 2'd2);
    en = 1'b0;
    step(1);  chk("en_drop",    12'h000, 2'd0);
    step(2);  chk("en_low",     12'h000, 2'd0);
    en = 1'b1;
    step(1);  chk("en_restart", 12'h001, 2'd1);
    step(3);  chk("en_hold3",   12'h001, 2'd1);
    step(1);  chk("en_shift4",  12'h002, 2'd1);

    // Run into FLASH (restart r, now r+4) and reset for one edge there.
    step(90); chk("pre_rst_flash", 12'hFFF, 2'd3);
    rst_n = 1'b1;
    step(1);  chk("rst_mid",    12'h000, 2'd0);
    rst_n = 1'b0;
    en    = 1'b0;
    step(2);  chk("post_rst_idle", 12'h000, 2'd0);
    en = 1'b1;
    step(1);  chk("post_rst_run", 12'h001, 2'd1);
    step(4);  chk("post_rst_shift", 12'h002, 2'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
